mem_system: RTL and testbench
=============================

Name: mem_system

Overview:
- 8-word × 8-bit register-file memory with a single shared address bus and a tri-state data output.
- One clock; writes are synchronous, reads are combinational.
- The output bus is driven only during a selected read and is high-impedance otherwise, so several mem_system instances can share one output bus.
- Internal structure: address decoder, 8 byte registers with write enables, 8:1 read multiplexer, and a tri-state output buffer.

Parameters:
- DATA_W, 8, word width in bits (i, o, each storage word).
- ADDR_W, 3, address width; depth = 2**ADDR_W = 8 words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all storage.
- i  input  DATA_W  write data.
- adr  input  ADDR_W  word address, used for both write and read.
- op  input  1  operation: 1 = write, 0 = read.
- select  input  1  chip select; 0 = idle, nothing written, o high-Z.
- o  output (tri-state)  DATA_W  read data; driven only when select=1 and op=0, else all bits Z.

Behaviour:
- Reset: rst=1 asynchronously clears all 8 words to 8'h00, regardless of clk. The reset is held for as long as rst=1, and writes are ignored while rst=1. o follows the normal output rule during reset, so a read during reset shows 8'h00.
- Reset mid-write: if rst asserts in the same cycle as a write, reset wins and the word stays 8'h00.
- Write: on rising clk with select=1, op=1 and rst=0, mem[adr] <= i. Exactly one word is updated, chosen by a one-hot decode of adr; all other words hold.
- Write latency: the new value is visible on a read starting after that clock edge.
- No write occurs when select=0, even if op=1.
- Read: when select=1 and op=0, o = mem[adr] combinationally, with no clock latency. A change of adr updates o within the same cycle.
- Tri-state rule: o = all-Z whenever select=0, or whenever op=1 (including during writes). There is no write-through to o.
- Address range: every value of adr (0..7) is valid. There is no out-of-range case and no wrap logic.
- Consecutive writes to different addresses on back-to-back cycles all take effect.
- Repeated writes to the same address: the last write wins.
- Contents are retained indefinitely while select=0 or op=0.
- No X propagation from an undriven memory: because of reset, every word has a defined value after the first rst pulse.

Test Plan:
- Reset then read: pulse rst, then select=1, op=0, sweep adr 0..7 -> o = 8'h00 at every address.
- Idle: select=0 with any op/adr -> o = 8'hZZ; a clock edge with op=1 writes nothing, and a subsequent read of that address still returns its old value.
- Write then read a string: write adr 0..7 = 0x4C, 0x53, 0x20, 0x53, 0x57, 0x4B, 0x20, 0x21 ("LS SWK !"), one word per clock. Then read adr 0..7, changing adr every cycle -> o returns the same bytes in the same cycle as each adr change.
- High-Z during write: while select=1 and op=1 -> o = 8'hZZ; after switching to op=0 with adr=3 -> o = 8'h53.
- Overwrite/isolation: write adr 5 = 0xAA, then adr 5 = 0x55 -> read adr 5 = 0x55; adr 4 still = 0x57 and adr 6 still = 0x20.
- Asynchronous reset mid-operation: after loading the string, assert rst between clock edges -> a read of any address gives 0x00 immediately, with no clock needed. A write attempted with rst=1 is ignored.

Source files
------------

// File: rtl/mem_system.sv
// mem_system: 8-word x 8-bit register-file memory with a shared address bus,
// synchronous writes, combinational reads and a tri-state output so several
// instances can share one read-data bus.

// One-hot write decoder: exactly one word enable is raised for an enabled write.
module mem_decoder #(
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic [ADDR_W-1:0] adr,
   input  logic              en,
   output logic [DEPTH-1:0]  onehot
);

   // Raise the enable of the addressed word only while a write is requested.
   always_comb begin
      onehot = {DEPTH{1'b0}};
      if (en) begin
         onehot[adr] = 1'b1;
      end else begin
         onehot = {DEPTH{1'b0}};
      end
   end

endmodule

// One storage word with its own write enable; cleared asynchronously.
module mem_word #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   // Reset dominates; otherwise capture on an enabled edge and hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= {DATA_W{1'b0}};
      end else if (we) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// Combinational read multiplexer over the flattened word array.
module mem_rdmux #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic [DEPTH*DATA_W-1:0] words,
   input  logic [ADDR_W-1:0]       adr,
   output logic [DATA_W-1:0]       rd_data
);

   // Pick the addressed word; every address value maps to a real word.
   always_comb begin
      rd_data = {DATA_W{1'b0}};
      for (int w = 0; w < DEPTH; w++) begin
         if (adr == w[ADDR_W-1:0]) begin
            rd_data = words[w*DATA_W +: DATA_W];
         end else begin
            rd_data = rd_data;
         end
      end
   end

endmodule

// Top level: decoder, word registers, read mux and tri-state output buffer.
module mem_system #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i,
   input  logic [ADDR_W-1:0] adr,
   input  logic              op,
   input  logic              select,
   output logic [DATA_W-1:0] o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic                    write_req;
   logic                    read_req;
   logic [DEPTH-1:0]        word_we;
   logic [DEPTH*DATA_W-1:0] words;
   logic [DATA_W-1:0]       rd_data;

   // Classify the current bus cycle; reset suppresses writes even if the
   // asynchronous clear would already override them.
   always_comb begin
      write_req = 1'b0;
      read_req  = 1'b0;
      if (select) begin
         write_req = op & ~rst;
         read_req  = ~op;
      end else begin
         write_req = 1'b0;
         read_req  = 1'b0;
      end
   end

   mem_decoder #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_decoder (
      .adr    (adr),
      .en     (write_req),
      .onehot (word_we)
   );

   for (genvar w = 0; w < DEPTH; w++) begin : g_word
      mem_word #(
         .DATA_W (DATA_W)
      ) u_word (
         .clk (clk),
         .rst (rst),
         .we  (word_we[w]),
         .d   (i),
         .q   (words[w*DATA_W +: DATA_W])
      );
   end

   mem_rdmux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_rdmux (
      .words   (words),
      .adr     (adr),
      .rd_data (rd_data)
   );

   // Drive the shared bus only for a selected read; release it otherwise,
   // including during writes (no write-through).
   assign o = read_req ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_system.sv
// Self-checking bench for mem_system. The output bus has a weak pull-up so a
// released (high-Z) bus reads as all ones in any simulator.
module tb_mem_system;

   logic       clk;
   logic       rst;
   logic [7:0] i;
   logic [2:0] adr;
   logic       op;
   logic       select;
   wire  [7:0] o_bus;

   int vectors;
   int miscompares;

   // Reference contents, updated from the behavioural rules only.
   logic [7:0] ref_mem [8];

   localparam logic [7:0] BUS_IDLE = 8'hFF;

   mem_system dut (
      .clk    (clk),
      .rst    (rst),
      .i      (i),
      .adr    (adr),
      .op     (op),
      .select (select),
      .o      (o_bus)
   );

   for (genvar b = 0; b < 8; b++) begin : g_pull
      pullup (o_bus[b]);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected bus value from the reference: driven only on a selected read.
   function automatic logic [7:0] expect_bus();
      if (select && !op) return ref_mem[adr];
      return BUS_IDLE;
   endfunction

   task automatic check(input string tag, input logic [7:0] exp);
      vectors++;
      assert (o_bus === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (adr=%0d sel=%b op=%b rst=%b)",
                tag, o_bus, exp, adr, select, op, rst);
      end
   endtask

   // Apply inputs in the low phase, check the combinational output, then
   // clock once and update the reference for any write that edge performs.
   task automatic step(input string tag, input logic s, input logic w,
                       input logic [2:0] a, input logic [7:0] d);
      select = s; op = w; adr = a; i = d;
      #1;
      check(tag, expect_bus());
      @(posedge clk);
      if (!rst && s && w) ref_mem[a] = d;
      @(negedge clk);
   endtask

   task automatic clear_ref();
      for (int k = 0; k < 8; k++) ref_mem[k] = 8'h00;
   endtask

   logic [7:0] str [8];

   initial begin
      vectors = 0;
      miscompares = 0;
      str[0] = 8'h4C; str[1] = 8'h53; str[2] = 8'h20; str[3] = 8'h53;
      str[4] = 8'h57; str[5] = 8'h4B; str[6] = 8'h20; str[7] = 8'h21;
      rst = 1'b0; select = 1'b0; op = 1'b0; adr = 3'd0; i = 8'h00;

      // Reset pulse, then read back zeros everywhere.
      @(negedge clk);
      rst = 1'b1; clear_ref();
      @(negedge clk);
      select = 1'b1; op = 1'b0; adr = 3'd4; #1;
      check("read_during_reset", 8'h00);
      rst = 1'b0;
      @(negedge clk);
      for (int a = 0; a < 8; a++) step("reset_read", 1'b1, 1'b0, a[2:0], 8'h00);

      // Load the string, one word per clock.
      for (int a = 0; a < 8; a++) step("write_str_z", 1'b1, 1'b1, a[2:0], str[a]);

      // Read back, changing adr each cycle; compare against fixed bytes too.
      for (int a = 0; a < 8; a++) begin
         select = 1'b1; op = 1'b0; adr = a[2:0]; #1;
         check("read_str", str[a]);
         @(negedge clk);
      end

      // Idle: no drive, and a write-op edge with select=0 changes nothing.
      step("idle_rd", 1'b0, 1'b0, 3'd2, 8'h00);
      step("idle_wr", 1'b0, 1'b1, 3'd2, 8'hEE);
      step("after_idle", 1'b1, 1'b0, 3'd2, 8'h00);
      check("after_idle_const", 8'h20);

      // High-Z during a selected write, then read adr 3.
      select = 1'b1; op = 1'b1; adr = 3'd3; i = 8'h53; #1;
      check("hiz_write", BUS_IDLE);
      op = 1'b0; #1;
      check("read_adr3", 8'h53);
      @(negedge clk);

      // Overwrite adr 5 twice; neighbours untouched.
      step("ovw1", 1'b1, 1'b1, 3'd5, 8'hAA);
      step("ovw2", 1'b1, 1'b1, 3'd5, 8'h55);
      select = 1'b1; op = 1'b0;
      adr = 3'd5; #1; check("ovw_adr5", 8'h55);
      adr = 3'd4; #1; check("iso_adr4", 8'h57);
      adr = 3'd6; #1; check("iso_adr6", 8'h20);
      @(negedge clk);

      // Asynchronous reset between edges: zero immediately, no clock.
      select = 1'b1; op = 1'b0; adr = 3'd0; #1;
      check("pre_rst_adr0", 8'h4C);
      #1 rst = 1'b1; clear_ref(); #1;
      check("async_rst_adr0", 8'h00);
      adr = 3'd7; #1;
      check("async_rst_adr7", 8'h00);
      @(negedge clk);
      // Write attempt while reset is held is ignored.
      step("wr_in_rst", 1'b1, 1'b1, 3'd2, 8'h77);
      rst = 1'b0;
      step("after_rst_wr", 1'b1, 1'b0, 3'd2, 8'h00);
      check("after_rst_wr_const", 8'h00);

      // Randomized traffic against the reference, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1; clear_ref();
         end else begin
            rst = 1'b0;
         end
         step("random", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 7)), 8'($urandom));
      end
      rst = 1'b0;
      @(negedge clk);
      // Final sweep of all words against the reference.
      for (int a = 0; a < 8; a++) step("final_sweep", 1'b1, 1'b0, a[2:0], 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
